// File: rtl/dm_store_buffer.sv
// Store buffer: encodes sw/sh/sb into word address, byte enables and
// lane-replicated data, queues them in a FIFO and drains under wen/ack.

module dm_sb_lane #(
    parameter int LANE = 0
) (
    input  logic [1:0] op,
    input  logic [1:0] a,
    input  logic [7:0] w_byte,
    input  logic [7:0] h_byte,
    input  logic [7:0] b_byte,
    output logic       be,
    output logic [7:0] lane_data
);
    localparam logic [1:0] LN = LANE[1:0];

    always_comb begin
        be        = 1'b0;
        lane_data = w_byte;
        case (op)
            2'b00: begin
                be        = 1'b1;
                lane_data = w_byte;
            end
            2'b01: begin
                be        = (a[1] == LN[1]);
                lane_data = h_byte;
            end
            2'b10: begin
                be        = (a == LN);
                lane_data = b_byte;
            end
            default: be = 1'b0;
        endcase
    end
endmodule

module dm_store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [1:0]       st_op,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    output logic             mem_wen,
    output logic [31:0]      mem_addr,
    output logic [3:0]       mem_be,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ack,
    input  logic [31:0]      ld_addr,
    output logic             ld_hit,
    output logic             misalign,
    output logic [31:0]      misalign_addr,
    output logic [PTR_W:0]   count
);
    localparam int NUM_LANES = 4;

    typedef struct packed {
        logic [29:0] waddr;
        logic [3:0]  be;
        logic [31:0] data;
    } sb_entry_t;

    sb_entry_t                       entries [DEPTH];
    sb_entry_t                       head;
    logic [PTR_W-1:0]                wr_ptr, rd_ptr;
    logic [NUM_LANES-1:0]            enc_be;
    logic [NUM_LANES-1:0][7:0]       enc_data;
    logic [DEPTH-1:0]                hit_vec;
    logic                            accept, legal, rsvd, push, pop, mis_now;
    logic                            unused_ld_lo;

    assign unused_ld_lo = ^ld_addr[1:0];

    // Per-byte-lane encoders: halfword lanes take the low or high byte of
    // st_data[15:0] by lane parity, byte lanes all replicate st_data[7:0].
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        dm_sb_lane #(.LANE(i)) u_lane (
            .op        (st_op),
            .a         (st_addr[1:0]),
            .w_byte    (st_data[8*i +: 8]),
            .h_byte    (st_data[8*(i%2) +: 8]),
            .b_byte    (st_data[7:0]),
            .be        (enc_be[i]),
            .lane_data (enc_data[i])
        );
    end

    always_comb begin
        legal = 1'b0;
        case (st_op)
            2'b00:   legal = (st_addr[1:0] == 2'b00);
            2'b01:   legal = ~st_addr[0];
            2'b10:   legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    assign st_ready = (count != (PTR_W+1)'(DEPTH));
    assign accept   = st_valid && st_ready;
    assign rsvd     = (st_op == 2'b11);
    assign push     = accept && legal;
    assign mis_now  = accept && !rsvd && !legal;
    assign mem_wen  = (count != '0);
    assign pop      = mem_ack && mem_wen;

    assign head      = entries[rd_ptr];
    assign mem_addr  = {head.waddr, 2'b00};
    assign mem_be    = head.be;
    assign mem_wdata = head.data;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            misalign      <= 1'b0;
            misalign_addr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            misalign <= mis_now;
            if (mis_now) misalign_addr <= st_addr;
        end
    end

    // Storage is never cleared; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) entries[wr_ptr] <= '{waddr: st_addr[31:2], be: enc_be, data: enc_data};
    end

    // An entry is occupied when its distance from rd_ptr is below count, so
    // the head still matches while being acked and a same-cycle push does not.
    for (genvar e = 0; e < DEPTH; e++) begin : g_hit
        logic [PTR_W-1:0] off;
        assign off        = PTR_W'(e) - rd_ptr;
        assign hit_vec[e] = ({1'b0, off} < count) && (entries[e].waddr == ld_addr[31:2]);
    end

    assign ld_hit = |hit_vec;
endmodule

// File: tb/tb_dm_store_buffer.sv
// Self-checking bench for dm_store_buffer: encoding vector table plus
// scoreboarded fill/drain, wrap, ld_hit and reset sequences.

module tb_dm_store_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  st_op;
    logic [31:0] st_addr, st_data;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic        misalign;
    logic [31:0] misalign_addr;
    logic [2:0]  count;

    dm_store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_op(st_op),
        .st_addr(st_addr), .st_data(st_data),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .ld_addr(ld_addr), .ld_hit(ld_hit),
        .misalign(misalign), .misalign_addr(misalign_addr), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic        q;
        logic        mis;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
    } vec_t;

    exp_t        sbq[$];
    vec_t        vt[9];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] last_mis = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; compares the head with the scoreboard and acks it.
    task automatic ack_head(input string nm);
        exp_t e;
        chk({nm, "_wen"}, 32'(mem_wen), 32'd1);
        if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_sb: got empty scoreboard expected entry", nm);
        end else begin
            e = sbq.pop_front();
            chk({nm, "_addr"}, mem_addr, e.addr);
            chk({nm, "_be"}, 32'(mem_be), 32'(e.be));
            chk({nm, "_wdata"}, mem_wdata, e.data);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
    endtask

    task automatic push_sw(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        chk("push_ready", 32'(st_ready), 32'd1);
        st_valid = 1'b1; st_op = 2'b00; st_addr = a; st_data = d;
        e.addr = a; e.be = 4'b1111; e.data = d;
        sbq.push_back(e);
        @(negedge clk);
        st_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sbq.delete();
        last_mis = '0;
    endtask

    initial begin
        exp_t e;
        vt[0] = '{2'b10, 32'h13,  32'h000000A5, 1, 0, 32'h10,  4'b1000, 32'hA5A5A5A5};
        vt[1] = '{2'b01, 32'h22,  32'h1234BEEF, 1, 0, 32'h20,  4'b1100, 32'hBEEFBEEF};
        vt[2] = '{2'b01, 32'h20,  32'h1234BEEF, 1, 0, 32'h20,  4'b0011, 32'hBEEFBEEF};
        vt[3] = '{2'b00, 32'h102, 32'h11111111, 0, 1, 32'h0,   4'b0000, 32'h0};
        vt[4] = '{2'b01, 32'h01,  32'h22222222, 0, 1, 32'h0,   4'b0000, 32'h0};
        vt[5] = '{2'b00, 32'h204, 32'hDEADBEEF, 1, 0, 32'h204, 4'b1111, 32'hDEADBEEF};
        vt[6] = '{2'b10, 32'h31,  32'h1234565A, 1, 0, 32'h30,  4'b0010, 32'h5A5A5A5A};
        vt[7] = '{2'b11, 32'h40,  32'h33333333, 0, 0, 32'h0,   4'b0000, 32'h0};
        vt[8] = '{2'b01, 32'h03,  32'h44444444, 0, 1, 32'h0,   4'b0000, 32'h0};

        reset = 1'b1; st_valid = 1'b0; st_op = '0; st_addr = '0; st_data = '0;
        mem_ack = 1'b0; ld_addr = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        chk("rst_wen", 32'(mem_wen), 32'd0);
        chk("rst_ready", 32'(st_ready), 32'd1);
        chk("rst_ldhit", 32'(ld_hit), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_mis", 32'(misalign), 32'd0);
        chk("rst_misaddr", misalign_addr, 32'd0);

        // Encoding table
        for (int i = 0; i < 9; i++) begin
            chk("vec_ready", 32'(st_ready), 32'd1);
            st_valid = 1'b1; st_op = vt[i].op; st_addr = vt[i].addr; st_data = vt[i].data;
            if (vt[i].q) begin
                e.addr = vt[i].e_addr; e.be = vt[i].e_be; e.data = vt[i].e_wdata;
                sbq.push_back(e);
            end
            if (vt[i].mis) last_mis = vt[i].addr;
            @(negedge clk);
            st_valid = 1'b0;
            chk("vec_count", 32'(count), vt[i].q ? 32'd1 : 32'd0);
            chk("vec_wen", 32'(mem_wen), 32'(vt[i].q));
            chk("vec_mis", 32'(misalign), 32'(vt[i].mis));
            chk("vec_misaddr", misalign_addr, last_mis);
            if (vt[i].q) ack_head("vec");
            else @(negedge clk);
            chk("vec_mis_pulse", 32'(misalign), 32'd0);
            chk("vec_count_end", 32'(count), 32'd0);
        end

        // Fill to full, fifth request held off
        do_reset();
        for (int i = 0; i < 4; i++) push_sw(32'h40 + 32'(4*i), 32'hA0000000 + 32'(i));
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(st_ready), 32'd0);
        st_valid = 1'b1; st_op = 2'b00; st_addr = 32'h50; st_data = 32'hA0000004;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("held_count", 32'(count), 32'd4);
            chk("held_ready", 32'(st_ready), 32'd0);
        end
        ack_head("drain0");
        chk("after_pop_count", 32'(count), 32'd3);
        chk("after_pop_ready", 32'(st_ready), 32'd1);
        e.addr = 32'h50; e.be = 4'b1111; e.data = 32'hA0000004;
        sbq.push_back(e);
        @(negedge clk);
        st_valid = 1'b0;
        chk("refill_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) ack_head("drain");
        chk("drained_count", 32'(count), 32'd0);
        chk("drained_wen", 32'(mem_wen), 32'd0);

        // Ack while empty is ignored
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("empty_ack_count", 32'(count), 32'd0);

        // Simultaneous push and pop across wr_ptr wrap
        do_reset();
        push_sw(32'h100, 32'h1);
        push_sw(32'h104, 32'h2);
        push_sw(32'h108, 32'h3);
        ack_head("pre_wrap");
        chk("wrap_start_count", 32'(count), 32'd2);
        for (int i = 0; i < 2; i++) begin
            e = sbq.pop_front();
            chk("sim_addr", mem_addr, e.addr);
            chk("sim_wdata", mem_wdata, e.data);
            st_valid = 1'b1; st_op = 2'b00; st_addr = 32'h10C + 32'(4*i); st_data = 32'h4 + 32'(i);
            mem_ack = 1'b1;
            e.addr = st_addr; e.be = 4'b1111; e.data = st_data;
            sbq.push_back(e);
            @(negedge clk);
            st_valid = 1'b0; mem_ack = 1'b0;
            chk("sim_count", 32'(count), 32'd2);
        end
        ack_head("post_wrap");
        ack_head("post_wrap");
        chk("wrap_end_count", 32'(count), 32'd0);

        // ld_hit
        do_reset();
        ld_addr = 32'h80;
        st_valid = 1'b1; st_op = 2'b00; st_addr = 32'h80; st_data = 32'hCAFEF00D;
        e.addr = 32'h80; e.be = 4'b1111; e.data = 32'hCAFEF00D;
        sbq.push_back(e);
        #1;
        chk("ldhit_pushing", 32'(ld_hit), 32'd0);
        @(negedge clk);
        st_valid = 1'b0;
        ld_addr = 32'h83;
        #1;
        chk("ldhit_83", 32'(ld_hit), 32'd1);
        ld_addr = 32'h84;
        #1;
        chk("ldhit_84", 32'(ld_hit), 32'd0);
        ld_addr = 32'h80;
        mem_ack = 1'b1;
        #1;
        chk("ldhit_acking", 32'(ld_hit), 32'd1);
        e = sbq.pop_front();
        chk("ldhit_head", mem_addr, e.addr);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("ldhit_after_ack", 32'(ld_hit), 32'd0);

        // Reset with entries queued; ack during reset ignored
        push_sw(32'h200, 32'h7);
        push_sw(32'h204, 32'h8);
        push_sw(32'h208, 32'h9);
        chk("pre_rst_count", 32'(count), 32'd3);
        mem_ack = 1'b1;
        do_reset();
        mem_ack = 1'b0;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_wen", 32'(mem_wen), 32'd0);
        chk("mid_rst_ready", 32'(st_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
